// File: rtl/x_ramb_pkg.sv
// Shared definitions for the asymmetric dual-port RAM: write-mode encoding,
// mode-string decoding, ceil(log2) and parameter validation helpers.
package x_ramb_pkg;

   typedef enum logic [1:0] {
      WM_WRITE_FIRST = 2'b00,
      WM_READ_FIRST  = 2'b01,
      WM_NO_CHANGE   = 2'b10,
      WM_INVALID     = 2'b11
   } wmode_e;

   function automatic wmode_e str_to_mode(input string s);
      if (s == "WRITE_FIRST") return WM_WRITE_FIRST;
      if (s == "READ_FIRST")  return WM_READ_FIRST;
      if (s == "NO_CHANGE")   return WM_NO_CHANGE;
      return WM_INVALID;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Geometry must be power-of-2 with WIDTH_A <= WIDTH_B <= MEM_BITS and both
   // mode strings recognised.
   function automatic bit params_ok(input int    mem_bits,
                                    input int    wa,
                                    input int    wb,
                                    input string ma,
                                    input string mb,
                                    input int    do_reg);
      return is_pow2(mem_bits) && is_pow2(wa) && is_pow2(wb) &&
             (wa <= wb) && (wb <= mem_bits) &&
             (str_to_mode(ma) != WM_INVALID) &&
             (str_to_mode(mb) != WM_INVALID) &&
             ((do_reg == 0) || (do_reg == 1));
   endfunction

endpackage

// File: rtl/x_ramb_port_out.sv
// Per-port output stage: write-mode selection, synchronous set/reset, optional
// pipeline register, and the collision flag carried alongside the data.
module x_ramb_port_out
   import x_ramb_pkg::*;
#(
   parameter int             W      = 1,
   parameter wmode_e         MODE   = WM_WRITE_FIRST,
   parameter int             DO_REG = 0,
   parameter logic [W-1:0]   INIT   = '0,
   parameter logic [W-1:0]   SRVAL  = '0
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_en,
   input  logic         i_we,
   input  logic         i_ssr,
   input  logic [W-1:0] i_din,
   input  logic [W-1:0] i_rdata,
   input  logic         i_coll,
   output logic [W-1:0] o_dout,
   output logic         o_coll
);

   logic [W-1:0] r_s1;
   logic [W-1:0] w_s1_nxt;
   logic         r_c1;

   // First-stage next value: SRVAL, plain read, or write-mode dependent data.
   always_comb begin
      w_s1_nxt = r_s1;
      if (i_en) begin
         if (i_ssr) begin
            w_s1_nxt = SRVAL;
         end else if (!i_we) begin
            w_s1_nxt = i_rdata;
         end else begin
            case (MODE)
               WM_WRITE_FIRST: w_s1_nxt = i_din;
               WM_READ_FIRST:  w_s1_nxt = i_rdata;
               default:        w_s1_nxt = r_s1;
            endcase
         end
      end
   end

   // First output stage; the collision flag is latched every edge so it lines
   // up with the data produced by the same edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1 <= INIT;
         r_c1 <= 1'b0;
      end else begin
         r_s1 <= w_s1_nxt;
         r_c1 <= i_coll;
      end
   end

   if (DO_REG != 0) begin : g_pipe
      logic [W-1:0] r_s2;
      logic         r_c2;

      // Pipeline register loads unconditionally, so EN and SSR only gate stage 1.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_s2 <= INIT;
            r_c2 <= 1'b0;
         end else begin
            r_s2 <= r_s1;
            r_c2 <= r_c1;
         end
      end

      assign o_dout = r_s2;
      assign o_coll = r_c2;
   end else begin : g_nopipe
      assign o_dout = r_s1;
      assign o_coll = r_c1;
   end

endmodule

// File: rtl/x_ramb_dp_asym.sv
// True dual-port RAM with asymmetric port widths over one shared bit array.
// Owns the array, address-to-bit mapping, collision detection and write order.
module x_ramb_dp_asym
   import x_ramb_pkg::*;
#(
   parameter int                    MEM_BITS     = 16384,
   parameter int                    WIDTH_A      = 1,
   parameter int                    WIDTH_B      = 8,
   parameter string                 WRITE_MODE_A = "WRITE_FIRST",
   parameter string                 WRITE_MODE_B = "WRITE_FIRST",
   parameter int                    DO_REG       = 0,
   parameter logic [WIDTH_A-1:0]    INIT_A       = '0,
   parameter logic [WIDTH_B-1:0]    INIT_B       = '0,
   parameter logic [WIDTH_A-1:0]    SRVAL_A      = '0,
   parameter logic [WIDTH_B-1:0]    SRVAL_B      = '0,
   parameter logic [MEM_BITS-1:0]   INIT_MEM     = '0
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic [clog2(MEM_BITS/WIDTH_A)-1:0]    i_addra,
   input  logic [WIDTH_A-1:0]                    i_dia,
   input  logic                                  i_ena,
   input  logic                                  i_wea,
   input  logic                                  i_ssra,
   input  logic [clog2(MEM_BITS/WIDTH_B)-1:0]    i_addrb,
   input  logic [WIDTH_B-1:0]                    i_dib,
   input  logic                                  i_enb,
   input  logic                                  i_web,
   input  logic                                  i_ssrb,
   output logic [WIDTH_A-1:0]                    o_doa,
   output logic [WIDTH_B-1:0]                    o_dob,
   output logic                                  o_coll
);

   localparam int     MB_W   = clog2(MEM_BITS);
   localparam int     SA     = clog2(WIDTH_A);
   localparam int     SB     = clog2(WIDTH_B);
   localparam wmode_e MODE_A = str_to_mode(WRITE_MODE_A);
   localparam wmode_e MODE_B = str_to_mode(WRITE_MODE_B);

   if (!params_ok(MEM_BITS, WIDTH_A, WIDTH_B, WRITE_MODE_A, WRITE_MODE_B, DO_REG)) begin : g_param_err
      $fatal(1, "x_ramb_dp_asym: invalid parameter set");
   end

   logic [MEM_BITS-1:0] r_mem = INIT_MEM;

   logic [MB_W-1:0]     w_base_a;
   logic [MB_W-1:0]     w_base_b;
   logic [WIDTH_A-1:0]  w_rd_a;
   logic [WIDTH_B-1:0]  w_rd_b;
   logic                w_overlap;
   logic                w_coll;
   logic                w_coll_a;
   logic                w_coll_b;

   assign w_base_a  = MB_W'(i_addra) << SA;
   assign w_base_b  = MB_W'(i_addrb) << SB;
   assign w_rd_a    = r_mem[w_base_a +: WIDTH_A];
   assign w_rd_b    = r_mem[w_base_b +: WIDTH_B];
   assign w_overlap = (w_base_a >> SB) == (w_base_b >> SB);
   assign w_coll    = i_ena && i_enb && w_overlap && (i_wea || i_web);

   // Array writes; the array is never cleared by reset, only writes are held
   // off. Port B is applied last so it owns overlapping bits on a double write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (i_rst_n) begin
         if (i_ena && i_wea) r_mem[w_base_a +: WIDTH_A] <= i_dia;
         if (i_enb && i_web) r_mem[w_base_b +: WIDTH_B] <= i_dib;
      end
   end

   x_ramb_port_out #(
      .W      (WIDTH_A),
      .MODE   (MODE_A),
      .DO_REG (DO_REG),
      .INIT   (INIT_A),
      .SRVAL  (SRVAL_A)
   ) u_out_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_ena),
      .i_we    (i_wea),
      .i_ssr   (i_ssra),
      .i_din   (i_dia),
      .i_rdata (w_rd_a),
      .i_coll  (w_coll),
      .o_dout  (o_doa),
      .o_coll  (w_coll_a)
   );

   x_ramb_port_out #(
      .W      (WIDTH_B),
      .MODE   (MODE_B),
      .DO_REG (DO_REG),
      .INIT   (INIT_B),
      .SRVAL  (SRVAL_B)
   ) u_out_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (i_enb),
      .i_we    (i_web),
      .i_ssr   (i_ssrb),
      .i_din   (i_dib),
      .i_rdata (w_rd_b),
      .i_coll  (w_coll),
      .o_dout  (o_dob),
      .o_coll  (w_coll_b)
   );

   // Both port stages carry the same collision event with the same latency.
   assign o_coll = w_coll_a | w_coll_b;

endmodule

// File: tb/tb_x_ramb_dp_asym.sv
// Bench for x_ramb_dp_asym: two instances (no output register / output
// register, covering all three write modes) driven by shared stimulus and
// compared against a bit-array reference model.
module tb_x_ramb_dp_asym;

   localparam logic [16383:0] INIT_M = 16384'hC3 << 56;
   // Write modes per instance: 0 write-first, 1 read-first, 2 no-change.
   localparam int MA [2] = '{1, 2};
   localparam int MB [2] = '{0, 1};
   localparam int DR [2] = '{0, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [13:0] addra = '0;
   logic        dia = 1'b0, ena = 1'b0, wea = 1'b0, ssra = 1'b0;
   logic [10:0] addrb = '0;
   logic [7:0]  dib = '0;
   logic        enb = 1'b0, web = 1'b0, ssrb = 1'b0;

   logic        got_a [2];
   logic [7:0]  got_b [2];
   logic        got_c [2];

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   x_ramb_dp_asym #(
      .WRITE_MODE_A ("READ_FIRST"), .WRITE_MODE_B ("WRITE_FIRST"), .DO_REG (0),
      .INIT_A (1'b1), .INIT_B (8'hA5), .SRVAL_B (8'h3C), .INIT_MEM (INIT_M)
   ) dut0 (
      .i_clk (clk), .i_rst_n (rst_n),
      .i_addra (addra), .i_dia (dia), .i_ena (ena), .i_wea (wea), .i_ssra (ssra),
      .i_addrb (addrb), .i_dib (dib), .i_enb (enb), .i_web (web), .i_ssrb (ssrb),
      .o_doa (got_a[0]), .o_dob (got_b[0]), .o_coll (got_c[0])
   );

   x_ramb_dp_asym #(
      .WRITE_MODE_A ("NO_CHANGE"), .WRITE_MODE_B ("READ_FIRST"), .DO_REG (1),
      .INIT_A (1'b1), .INIT_B (8'hA5), .SRVAL_B (8'h3C), .INIT_MEM (INIT_M)
   ) dut1 (
      .i_clk (clk), .i_rst_n (rst_n),
      .i_addra (addra), .i_dia (dia), .i_ena (ena), .i_wea (wea), .i_ssra (ssra),
      .i_addrb (addrb), .i_dib (dib), .i_enb (enb), .i_web (web), .i_ssrb (ssrb),
      .o_doa (got_a[1]), .o_dob (got_b[1]), .o_coll (got_c[1])
   );

   // ---------------- reference model ----------------
   bit          mem [16384];
   logic        m_a1 [2], m_a2 [2], m_c1 [2], m_c2 [2];
   logic [7:0]  m_b1 [2], m_b2 [2];

   function automatic logic [7:0] rd_byte(input int k);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = mem[k * 8 + i];
      return r;
   endfunction

   function automatic logic [9:0] exp_out(input int d);
      if (DR[d] != 0) return {m_a2[d], m_b2[d], m_c2[d]};
      return {m_a1[d], m_b1[d], m_c1[d]};
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_a1[d] = 1'b1; m_a2[d] = 1'b1;
         m_b1[d] = 8'hA5; m_b2[d] = 8'hA5;
         m_c1[d] = 1'b0; m_c2[d] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic       oa;
      logic [7:0] ob;
      logic       coll;
      if (!rst_n) return;
      oa   = mem[int'(addra)];
      ob   = rd_byte(int'(addrb));
      coll = ena && enb && (int'(addra) / 8 == int'(addrb)) && (wea || web);
      for (int d = 0; d < 2; d++) begin
         m_a2[d] = m_a1[d]; m_b2[d] = m_b1[d]; m_c2[d] = m_c1[d];
         m_c1[d] = coll;
         if (ena) begin
            if (ssra)           m_a1[d] = 1'b0;
            else if (!wea)      m_a1[d] = oa;
            else if (MA[d] == 0) m_a1[d] = dia;
            else if (MA[d] == 1) m_a1[d] = oa;
         end
         if (enb) begin
            if (ssrb)           m_b1[d] = 8'h3C;
            else if (!web)      m_b1[d] = ob;
            else if (MB[d] == 0) m_b1[d] = dib;
            else if (MB[d] == 1) m_b1[d] = ob;
         end
      end
      if (ena && wea) mem[int'(addra)] = dia;
      if (enb && web) for (int i = 0; i < 8; i++) mem[int'(addrb) * 8 + i] = dib[i];
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      ena = 1'b0; wea = 1'b0; ssra = 1'b0;
      enb = 1'b0; web = 1'b0; ssrb = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({got_a[d], got_b[d], got_c[d]} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL reset_async dut%0d got a=%b b=%h c=%b need a=1 b=a5 c=0", d, got_a[d], got_b[d], got_c[d]);
         else n_pass++;
      end
      tick();
      rst_n = 1'b1;
      idle();
      tick();
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({got_a[d], got_b[d], got_c[d]} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL reset_idle dut%0d got a=%b b=%h c=%b need a=1 b=a5 c=0", d, got_a[d], got_b[d], got_c[d]);
         else n_pass++;
      end
   endtask

   task automatic test_write_read();
      logic [7:0] pat;
      pat = 8'h5A;
      enb = 1'b1; web = 1'b1; addrb = 11'd3; dib = 8'h5A;
      tick();
      n_chk++;
      if (got_b[0] !== 8'h5A) $display("FAIL b_write_first got %h need 5a", got_b[0]);
      else n_pass++;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({got_a[d], got_b[d], got_c[d]} !== exp_out(d))
            $display("FAIL b_write dut%0d got %b need %b", d, {got_a[d], got_b[d], got_c[d]}, exp_out(d));
         else n_pass++;
      end
      idle();
      for (int j = 0; j < 8; j++) begin
         ena = 1'b1; addra = 14'(24 + j);
         tick();
         n_chk++;
         if (got_a[0] !== pat[j]) $display("FAIL a_bit_read addr=%0d got %b need %b", 24 + j, got_a[0], pat[j]);
         else n_pass++;
         n_chk++;
         if ({got_a[1], got_b[1], got_c[1]} !== exp_out(1))
            $display("FAIL a_bit_read_reg addr=%0d got %b need %b", 24 + j, {got_a[1], got_b[1], got_c[1]}, exp_out(1));
         else n_pass++;
      end
      idle();
   endtask

   task automatic test_read_first();
      ena = 1'b1; wea = 1'b1; addra = 14'd0; dia = 1'b1;
      tick();
      n_chk++;
      if (got_a[0] !== 1'b0) $display("FAIL a_read_first_old got %b need 0", got_a[0]);
      else n_pass++;
      wea = 1'b0;
      tick();
      n_chk++;
      if (got_a[0] !== 1'b1) $display("FAIL a_read_after_write got %b need 1", got_a[0]);
      else n_pass++;
      n_chk++;
      if ({got_a[1], got_b[1], got_c[1]} !== exp_out(1))
         $display("FAIL read_first_reg got %b need %b", {got_a[1], got_b[1], got_c[1]}, exp_out(1));
      else n_pass++;
      idle();
   endtask

   task automatic test_collision();
      ena = 1'b1; wea = 1'b1; addra = 14'd25; dia = 1'b1;
      enb = 1'b1; web = 1'b1; addrb = 11'd3; dib = 8'h00;
      tick();
      n_chk++;
      if (got_c[0] !== 1'b1) $display("FAIL coll_ww got %b need 1", got_c[0]);
      else n_pass++;
      idle();
      tick();
      n_chk++;
      if (got_c[0] !== 1'b0) $display("FAIL coll_one_cycle got %b need 0", got_c[0]);
      else n_pass++;
      n_chk++;
      if (got_c[1] !== 1'b1) $display("FAIL coll_ww_reg got %b need 1", got_c[1]);
      else n_pass++;
      ena = 1'b1; addra = 14'd25;
      tick();
      n_chk++;
      if (got_a[0] !== 1'b0) $display("FAIL coll_b_wins got %b need 0", got_a[0]);
      else n_pass++;
      ena = 1'b1; wea = 1'b1; addra = 14'd26; dia = 1'b1;
      enb = 1'b1; web = 1'b0; addrb = 11'd3;
      tick();
      n_chk++;
      if ({got_b[0], got_c[0]} !== {8'h00, 1'b1})
         $display("FAIL coll_rw got b=%h c=%b need b=00 c=1", got_b[0], got_c[0]);
      else n_pass++;
      idle();
      enb = 1'b1; addrb = 11'd3;
      tick();
      n_chk++;
      if (got_b[0] !== 8'h04) $display("FAIL coll_rw_after got %h need 04", got_b[0]);
      else n_pass++;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({got_a[d], got_b[d], got_c[d]} !== exp_out(d))
            $display("FAIL coll_model dut%0d got %b need %b", d, {got_a[d], got_b[d], got_c[d]}, exp_out(d));
         else n_pass++;
      end
      idle();
   endtask

   task automatic test_pipeline();
      enb = 1'b1; web = 1'b1; addrb = 11'd5; dib = 8'h5A;
      tick();
      idle();
      tick();
      tick();
      enb = 1'b1; addrb = 11'd5;
      tick();
      n_chk++;
      if ({got_a[1], got_b[1], got_c[1]} !== exp_out(1))
         $display("FAIL pipe_first_edge got %b need %b", {got_a[1], got_b[1], got_c[1]}, exp_out(1));
      else n_pass++;
      idle();
      tick();
      n_chk++;
      if (got_b[1] !== 8'h5A) $display("FAIL pipe_read got %h need 5a", got_b[1]);
      else n_pass++;
      enb = 1'b1; ssrb = 1'b1;
      tick();
      idle();
      tick();
      n_chk++;
      if (got_b[1] !== 8'h3C) $display("FAIL pipe_ssr got %h need 3c", got_b[1]);
      else n_pass++;
      n_chk++;
      if (got_b[0] !== 8'h3C) $display("FAIL ssr_direct got %h need 3c", got_b[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      enb = 1'b1; web = 1'b1; addrb = 11'd7; dib = 8'hFF;
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if ({got_a[d], got_b[d], got_c[d]} !== {1'b1, 8'hA5, 1'b0})
            $display("FAIL reset_mid dut%0d got a=%b b=%h c=%b need a=1 b=a5 c=0", d, got_a[d], got_b[d], got_c[d]);
         else n_pass++;
      end
      tick();
      rst_n = 1'b1;
      idle();
      tick();
      enb = 1'b1; addrb = 11'd7;
      tick();
      idle();
      tick();
      for (int d = 0; d < 2; d++) begin
         n_chk++;
         if (got_b[d] !== 8'hC3) $display("FAIL write_dropped dut%0d got %h need c3", d, got_b[d]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         ena   = ($urandom_range(3) != 0);
         wea   = $urandom_range(1);
         ssra  = ($urandom_range(9) == 0);
         addra = 14'($urandom_range(31));
         dia   = $urandom_range(1);
         enb   = ($urandom_range(3) != 0);
         web   = $urandom_range(1);
         ssrb  = ($urandom_range(9) == 0);
         addrb = 11'($urandom_range(3));
         dib   = 8'($urandom);
         tick();
         for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({got_a[d], got_b[d], got_c[d]} !== exp_out(d))
               $display("FAIL random cyc=%0d dut%0d got %b need %b", n, d, {got_a[d], got_b[d], got_c[d]}, exp_out(d));
            else n_pass++;
         end
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = INIT_M[i];
      model_reset();
      test_reset();
      test_write_read();
      test_read_first();
      test_collision();
      test_pipeline();
      test_reset_mid_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
